icache_ctrl: RTL and testbench
==============================

# icache_ctrl

Direct-mapped, 4-line instruction cache controller sitting between the fetch stage of the 5-stage MIPS pipeline and the instruction memory. It serves hits in the cycle they are requested. On a miss it asserts `stall` to freeze the pipeline, runs a request/ready refill from instruction memory, installs the line, then lets the held PC re-look-up and hit. It also owns line invalidation (`flush`) and optional hit/miss statistics.

## Interface
- `TAG_W`, 28, tag width; the address splits as tag `pc[31:4]`, index `pc[3:2]`, byte offset `pc[1:0]`.
- `LINES`, 4, number of one-word lines; fixed as 2**2. The index width is 2.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `fetch_req`  in  1  fetch stage requests the instruction at `pc` this cycle.
- `pc`  in  32  fetch address; `pc[1:0]` is ignored.
- `flush`  in  1  invalidate all lines.
- `instr`  out  32  line data on a hit, else 0.
- `instr_valid`  out  1  `instr` is valid this cycle.
- `stall`  out  1  pipeline must hold `pc` and the IF/ID register.
- `mem_req`  out  1  refill request to instruction memory.
- `mem_addr`  out  32  word-aligned refill address, `{pc[31:2],2'b00}`.
- `mem_ready`  in  1  `mem_data` is valid; completes the request.
- `mem_data`  in  32  refill word.
- `hit_count`  out  16  present only with `ICACHE_STATS_EN`.
- `miss_count`  out  16  present only with `ICACHE_STATS_EN`.

## Operation
- Per-line storage: `valid`, `tag[TAG_W]`, `data[32]`.
- Combinational hit: `hit = fetch_req && state==IDLE && valid[idx] && tag[idx]==pc[31:4]`.
- State machine states:
  - IDLE:
    - On a hit: `instr_valid=1`, `instr=data[idx]`, `stall=0`.
    - On `fetch_req && !hit`: `stall=1` in the same cycle. Latch the address into `mem_addr`. Go to REFILL.
  - REFILL:
    - `mem_req=1`, `stall=1`, `instr_valid=0`. `mem_addr` is held stable.
    - On an edge with `mem_ready=1`: capture `mem_data`. Write `tag` and `data`. Set `valid` unless `drop` is set. Clear `drop`. Go to IDLE.
- Retry: after a refill, the stalled pipeline re-presents the same `pc` and hits in IDLE.
- `flush`:
  - In IDLE: all `valid` bits clear at the next edge. A hit in that same cycle is still served from the pre-flush contents.
  - In REFILL: all `valid` bits clear and `drop` is set. The in-flight word is still written but left invalid, so the retry misses again and re-fetches.
- `mem_ready` outside REFILL is ignored.
- Conflict: a fill overwrites the indexed line unconditionally. There is no replacement choice.
- `fetch_req=0` in IDLE: `stall=0` and `instr_valid=0`.
- Reset (asynchronous, any state, including mid-refill):
  - State returns to IDLE. All `valid`, `drop` and the counters clear. `mem_addr` is set to 0.
  - `mem_req`, `stall`, `instr_valid` drop to 0 immediately; `instr` is 0.
  - A pending memory response is abandoned.

## Timing
- Hit latency: 0 cycles, combinational from `pc` and `fetch_req`.
- `mem_req` rises the cycle after miss detection. It stays high until the edge that samples `mem_ready=1`, and is low in the following cycle.
- `mem_data` is sampled only on the `mem_ready` edge.
- Miss penalty with memory wait N cycles (`mem_ready` first high in the (N+1)th REFILL cycle):
  - `stall` is high for N+2 cycles.
  - `instr_valid` rises in cycle N+3, counted from the miss cycle.
  - Minimum case (N=0): the miss is in cycle 1 and the hit in cycle 3.
- No back-to-back refills without an intervening IDLE cycle.

## Configuration
- `ICACHE_STATS_EN` defined: adds two 16-bit saturating counters (saturate at 0xFFFF), cleared only by reset.
  - `hit_count` increments on each IDLE hit, excluding the first hit after a fill (the retry, tracked by a one-bit `retry` flag set on fill, cleared at the next IDLE cycle).
  - `miss_count` increments on each IDLE→REFILL transition.
- `ICACHE_STATS_EN` not defined: the counters, the `retry` flag and both output ports are absent. Cache behaviour is identical.

## Test plan
- Cold miss, pc=0x40, `mem_ready` in the first REFILL cycle with data 0x8C010004 → `stall` is high for 2 cycles, `mem_addr`=0x40, and `instr`=0x8C010004 with `instr_valid` in cycle 3. pc=0x40 again → hit in 0 cycles.
- Conflict: fill 0x40, then pc=0x80 (same index 0, different tag) → miss and refill. pc=0x40 then misses again.
- Memory wait N=3 on pc=0x44 → `mem_req` is high for exactly 4 cycles, `mem_addr` is stable, `stall` is high for 5 cycles.
- Fill all 4 lines (0x0, 0x4, 0x8, 0xC), pulse `flush` in IDLE → the next access to each address misses. A hit in the flush cycle still returns valid data.
- `flush` during REFILL of 0x8 → the fill completes, the retry misses, and a second `mem_req` goes out for 0x8.
- `reset` low mid-refill → `mem_req` and `stall` drop asynchronously. After release, pc=0x8 misses. With stats enabled, one miss plus one retry reads `hit_count`=0, `miss_count`=1; forcing 70000 hits saturates `hit_count` at 0xFFFF.

Source files
------------

// File: rtl/icache_ctrl.sv
// Direct-mapped 4-line instruction cache controller with request/ready refill and flush.
// Optional hit/miss statistics are built when ICACHE_STATS_EN is defined.
module icache_ctrl #(
    parameter int TAG_W = 28,
    parameter int LINES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [31:0] pc,
    input  logic        flush,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_data
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_e;

    state_e           state_q;
    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];
    logic             drop_q;
    logic             mem_req_q;
    logic [31:0]      mem_addr_q;

    logic [1:0]       idx;
    logic [1:0]       fill_idx;
    logic [TAG_W-1:0] pc_tag;
    logic [TAG_W-1:0] fill_tag;
    logic             hit;
    logic             miss;
    logic             unused_pc_bits;

    assign idx            = pc[3:2];
    assign pc_tag         = pc[31 -: TAG_W];
    assign fill_idx       = mem_addr_q[3:2];
    assign fill_tag       = mem_addr_q[31 -: TAG_W];
    assign unused_pc_bits = ^pc[1:0];

    // Outputs are gated by reset so the pipeline sees no stall or hit while reset is held.
    assign hit  = reset && fetch_req && (state_q == IDLE) && valid_q[idx] && (tag_q[idx] == pc_tag);
    assign miss = reset && fetch_req && (state_q == IDLE) && !hit;

    assign instr       = hit ? data_q[idx] : 32'h0;
    assign instr_valid = hit;
    assign stall       = miss || (state_q == REFILL);
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;

    // Main FSM: the fill write is placed after the flush clear so the filled line's
    // valid bit reflects drop/flush rather than being wiped unconditionally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            drop_q     <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 32'h0;
            for (int i = 0; i < LINES; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= 32'h0;
            end
        end else if (state_q == IDLE) begin
            if (flush) begin
                valid_q <= '0;
            end
            if (miss) begin
                mem_addr_q <= {pc[31:2], 2'b00};
                mem_req_q  <= 1'b1;
                state_q    <= REFILL;
            end
        end else begin
            if (flush) begin
                valid_q <= '0;
                drop_q  <= 1'b1;
            end
            if (mem_ready) begin
                tag_q[fill_idx]   <= fill_tag;
                data_q[fill_idx]  <= mem_data;
                valid_q[fill_idx] <= !(drop_q || flush);
                drop_q            <= 1'b0;
                mem_req_q         <= 1'b0;
                state_q           <= IDLE;
            end
        end
    end

`ifdef ICACHE_STATS_EN
    logic [15:0] hit_count_q;
    logic [15:0] hit_count_d;
    logic [15:0] miss_count_q;
    logic [15:0] miss_count_d;
    logic        retry_q;

    // The retry hit following a fill is the tail of a miss, so it is not counted as a hit.
    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (hit && !retry_q && (hit_count_q != 16'hFFFF)) begin
            hit_count_d = hit_count_q + 16'd1;
        end
        if (miss && (miss_count_q != 16'hFFFF)) begin
            miss_count_d = miss_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_count_q  <= 16'h0;
            miss_count_q <= 16'h0;
            retry_q      <= 1'b0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            if (state_q == REFILL && mem_ready) begin
                retry_q <= 1'b1;
            end else if (state_q == IDLE) begin
                retry_q <= 1'b0;
            end
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: scoreboarded fetches with a bench-side memory responder.
// Define ICACHE_STATS_EN when compiling to also exercise the statistics counters.
module tb_icache_ctrl;

    logic        clk;
    logic        reset;
    logic        fetch_req;
    logic [31:0] pc;
    logic        flush;
    logic [31:0] instr;
    logic        instr_valid;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_data;
`ifdef ICACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] expQ[$];

    icache_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_req  (fetch_req),
        .pc         (pc),
        .flush      (flush),
        .instr      (instr),
        .instr_valid(instr_valid),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_data   (mem_data)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one fetch from a negedge until it hits, acting as instruction memory with
    // n wait cycles per refill; optionally flushes in the first cycle of the first refill.
    task automatic run_fetch(input logic [31:0] a, input int n, input logic [31:0] d,
                             input bit flushInRefill,
                             output int stallCyc, output int reqCyc, output int latency,
                             output int fills, output logic [31:0] gotInstr,
                             output logic [31:0] gotAddr, output bit addrStable, output bit ok);
        int cyc = 0;
        int refillCyc = 0;
        bit addrSeen = 0;
        stallCyc = 0; reqCyc = 0; latency = 0; fills = 0;
        gotInstr = '0; gotAddr = '0; addrStable = 1; ok = 0;
        fetch_req = 1'b1;
        pc = a;
        while (!ok && cyc < 60) begin
            cyc++;
            #1;
            if (instr_valid) begin
                gotInstr = instr;
                latency  = cyc;
                ok       = 1;
            end
            if (stall) stallCyc++;
            if (mem_req) begin
                reqCyc++;
                if (!addrSeen) begin
                    gotAddr  = mem_addr;
                    addrSeen = 1;
                end else if (mem_addr !== gotAddr) begin
                    addrStable = 0;
                end
                flush = flushInRefill && fills == 0 && refillCyc == 0;
                if (refillCyc == n) begin
                    mem_ready = 1'b1;
                    mem_data  = d;
                end
                refillCyc++;
            end
            @(posedge clk);
            if (mem_ready) begin
                fills++;
                refillCyc = 0;
            end
            @(negedge clk);
            mem_ready = 1'b0;
            mem_data  = '0;
            flush     = 1'b0;
        end
        fetch_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; fetch_req = 1'b1; pc = 32'h40; flush = 1'b0;
        mem_ready = 1'b0; mem_data = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got %b want 0", stall); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_req got %b want 0", mem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_instr_valid got %b want 0", instr_valid); end
        checks++; if (instr !== 32'h0) begin errors++; $display("[TB] FAIL reset_instr got %h want 0", instr); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_addr got %h want 0", mem_addr); end
        fetch_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_cold_miss();
        int s, r, l, f; logic [31:0] gi, ga; bit st, ok; logic [31:0] e;
        expQ.push_back(32'h8C010004);
        run_fetch(32'h40, 0, 32'h8C010004, 0, s, r, l, f, gi, ga, st, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL cold_done got %b want 1", ok); end
        checks++; if (s != 2) begin errors++; $display("[TB] FAIL cold_stall_cycles got %0d want 2", s); end
        checks++; if (l != 3) begin errors++; $display("[TB] FAIL cold_latency got %0d want 3", l); end
        checks++; if (ga !== 32'h40) begin errors++; $display("[TB] FAIL cold_mem_addr got %h want 00000040", ga); end
        e = expQ.pop_front();
        checks++; if (gi !== e) begin errors++; $display("[TB] FAIL cold_instr got %h want %h", gi, e); end
        expQ.push_back(32'h8C010004);
        run_fetch(32'h40, 0, 32'hDEADBEEF, 0, s, r, l, f, gi, ga, st, ok);
        checks++; if (l != 1 || s != 0 || r != 0) begin errors++; $display("[TB] FAIL warm_hit got lat=%0d stall=%0d req=%0d want 1/0/0", l, s, r); end
        e = expQ.pop_front();
        checks++; if (gi !== e) begin errors++; $display("[TB] FAIL warm_instr got %h want %h", gi, e); end
    endtask

    task automatic test_conflict();
        int s, r, l, f; logic [31:0] gi, ga; bit st, ok; logic [31:0] e;
        expQ.push_back(32'h11110080);
        run_fetch(32'h80, 0, 32'h11110080, 0, s, r, l, f, gi, ga, st, ok);
        checks++; if (f != 1 || ga !== 32'h80) begin errors++; $display("[TB] FAIL conflict_80_fill got fills=%0d addr=%h want 1/00000080", f, ga); end
        e = expQ.pop_front();
        checks++; if (gi !== e) begin errors++; $display("[TB] FAIL conflict_80_instr got %h want %h", gi, e); end
        expQ.push_back(32'h22220040);
        run_fetch(32'h40, 0, 32'h22220040, 0, s, r, l, f, gi, ga, st, ok);
        checks++; if (f != 1) begin errors++; $display("[TB] FAIL conflict_40_refill got fills=%0d want 1", f); end
        e = expQ.pop_front();
        checks++; if (gi !== e) begin errors++; $display("[TB] FAIL conflict_40_instr got %h want %h", gi, e); end
    endtask

    task automatic test_mem_wait();
        int s, r, l, f; logic [31:0] gi, ga; bit st, ok; logic [31:0] e;
        expQ.push_back(32'h33330044);
        run_fetch(32'h44, 3, 32'h33330044, 0, s, r, l, f, gi, ga, st, ok);
        checks++; if (r != 4) begin errors++; $display("[TB] FAIL wait_mem_req_cycles got %0d want 4", r); end
        checks++; if (s != 5) begin errors++; $display("[TB] FAIL wait_stall_cycles got %0d want 5", s); end
        checks++; if (l != 6) begin errors++; $display("[TB] FAIL wait_latency got %0d want 6", l); end
        checks++; if (st !== 1'b1 || ga !== 32'h44) begin errors++; $display("[TB] FAIL wait_addr got stable=%b addr=%h want 1/00000044", st, ga); end
        e = expQ.pop_front();
        checks++; if (gi !== e) begin errors++; $display("[TB] FAIL wait_instr got %h want %h", gi, e); end
    endtask

    task automatic test_flush_idle();
        int s, r, l, f; logic [31:0] gi, ga; bit st, ok; logic [31:0] e;
        for (int i = 0; i < 4; i++) begin
            run_fetch(32'(i * 4), 0, 32'hA0000000 + 32'(i), 0, s, r, l, f, gi, ga, st, ok);
        end
        fetch_req = 1'b1; pc = 32'h4; flush = 1'b1;
        expQ.push_back(32'hA0000001);
        #1;
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL flush_cycle_valid got %b want 1", instr_valid); end
        e = expQ.pop_front();
        checks++; if (instr !== e) begin errors++; $display("[TB] FAIL flush_cycle_instr got %h want %h", instr, e); end
        @(negedge clk);
        fetch_req = 1'b0; flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expQ.push_back(32'hB0000000 + 32'(i));
            run_fetch(32'(i * 4), 0, 32'hB0000000 + 32'(i), 0, s, r, l, f, gi, ga, st, ok);
            checks++; if (f != 1) begin errors++; $display("[TB] FAIL flush_refetch_%0d got fills=%0d want 1", i, f); end
            e = expQ.pop_front();
            checks++; if (gi !== e) begin errors++; $display("[TB] FAIL flush_instr_%0d got %h want %h", i, gi, e); end
        end
    endtask

    task automatic test_flush_refill();
        int s, r, l, f; logic [31:0] gi, ga; bit st, ok; logic [31:0] e;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        expQ.push_back(32'hC0000008);
        run_fetch(32'h8, 1, 32'hC0000008, 1, s, r, l, f, gi, ga, st, ok);
        checks++; if (f != 2) begin errors++; $display("[TB] FAIL flush_refill_fills got %0d want 2", f); end
        checks++; if (l != 7 || s != 6) begin errors++; $display("[TB] FAIL flush_refill_timing got lat=%0d stall=%0d want 7/6", l, s); end
        checks++; if (ga !== 32'h8 || st !== 1'b1) begin errors++; $display("[TB] FAIL flush_refill_addr got %h stable=%b want 00000008/1", ga, st); end
        e = expQ.pop_front();
        checks++; if (gi !== e) begin errors++; $display("[TB] FAIL flush_refill_instr got %h want %h", gi, e); end
    endtask

    task automatic test_reset_midrefill();
        int s, r, l, f; logic [31:0] gi, ga; bit st, ok; logic [31:0] e;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; fetch_req = 1'b1; pc = 32'h8;
        #1;
        for (int i = 0; i < 10 && !mem_req; i++) begin
            @(negedge clk);
            #1;
        end
        checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL midrefill_req_seen got %b want 1", mem_req); end
        #1 reset = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || stall !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_outputs got req=%b stall=%b valid=%b want 0/0/0", mem_req, stall, instr_valid); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL async_reset_addr got %h want 0", mem_addr); end
        @(negedge clk);
        fetch_req = 1'b0; reset = 1'b1;
        @(negedge clk);
        expQ.push_back(32'hD0000008);
        run_fetch(32'h8, 0, 32'hD0000008, 0, s, r, l, f, gi, ga, st, ok);
        checks++; if (f != 1 || l != 3) begin errors++; $display("[TB] FAIL post_reset_miss got fills=%0d lat=%0d want 1/3", f, l); end
        e = expQ.pop_front();
        checks++; if (gi !== e) begin errors++; $display("[TB] FAIL post_reset_instr got %h want %h", gi, e); end
    endtask

`ifdef ICACHE_STATS_EN
    task automatic test_stats();
        int expHits;
        #1;
        checks++; if (hit_count !== 16'd0 || miss_count !== 16'd1) begin errors++; $display("[TB] FAIL stats_after_retry got hit=%0d miss=%0d want 0/1", hit_count, miss_count); end
        @(negedge clk);
        fetch_req = 1'b1; pc = 32'h8;
        repeat (70000) @(negedge clk);
        fetch_req = 1'b0;
        expHits = (70000 > 65535) ? 65535 : 70000;
        #1;
        checks++; if (hit_count !== 16'(expHits)) begin errors++; $display("[TB] FAIL stats_saturate got %h want %h", hit_count, 16'(expHits)); end
        checks++; if (miss_count !== 16'd1) begin errors++; $display("[TB] FAIL stats_miss_hold got %0d want 1", miss_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_cold_miss();
        test_conflict();
        test_mem_wait();
        test_flush_idle();
        test_flush_refill();
        test_reset_midrefill();
`ifdef ICACHE_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
